// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, fault codes and FSM state type for the instruction memory (parity option: IMEM_PARITY_EN)
package imem_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_MISAL = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;
    localparam logic [1:0] FLT_PAR   = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_LOAD
    } state_t;

    // Even parity: stored bit makes the XOR of word plus bit equal zero.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_sdp_loader_if.sv
// rtl/imem_sdp_loader_if.sv - fetch and program-load port bundle for imem_sdp_loader
interface imem_sdp_loader_if #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
    logic [1:0]        fetch_fault;

    logic              ld_start;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_end;
    logic [PTR_W-1:0]  ld_ptr;
    logic              ld_overflow;

    modport master (
        output fetch_req, fetch_addr, ld_start, ld_valid, ld_data, ld_end,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault, ld_ptr, ld_overflow
    );

    modport slave (
        input  fetch_req, fetch_addr, ld_start, ld_valid, ld_data, ld_end,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault, ld_ptr, ld_overflow
    );

endinterface

// File: rtl/imem_sdp_ram.sv
// rtl/imem_sdp_ram.sv - simple dual-port synchronous RAM with image init and optional parity column (IMEM_PARITY_EN)
module imem_sdp_ram
    import imem_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data,
    output logic                     rd_par_err
);

    typedef logic [DEPTH-1:0][31:0] image_t;

    // Power-up image: NOP in every word.
    function automatic image_t load_image();
        image_t img;
        for (int i = 0; i < DEPTH; i++) img[i] = NOP_INSN;
        return img;
    endfunction

    // Contents survive reset; only the power-up image initialises them.
    image_t mem = load_image();

`ifdef IMEM_PARITY_EN
    function automatic logic [DEPTH-1:0] image_parity(input image_t img);
        logic [DEPTH-1:0] p;
        for (int i = 0; i < DEPTH; i++) p[i] = even_parity(img[i]);
        return p;
    endfunction

    logic [DEPTH-1:0] par_mem = image_parity(load_image());
    logic             par_err_q;

    // Load port: store word and its parity bit together.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr]     <= wr_data;
            par_mem[wr_addr] <= even_parity(wr_data);
        end
    end

    // Registered read port; the parity verdict is held alongside the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data   <= NOP_INSN;
            par_err_q <= 1'b0;
        end else if (rd_en) begin
            rd_data   <= mem[rd_addr];
            par_err_q <= even_parity(mem[rd_addr]) != par_mem[rd_addr];
        end
    end

    assign rd_par_err = par_err_q;
`else
    // Load port write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the output register holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= NOP_INSN;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/imem_sdp_loader.sv
// rtl/imem_sdp_loader.sv - instruction memory with ready/valid fetch port and streaming program loader (parity option: IMEM_PARITY_EN)
module imem_sdp_loader
    import imem_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               reset,
    imem_sdp_loader_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              wr_en;

    logic              accept;
    logic [ADDR_W-3:0] word_idx;
    logic              misal;
    logic              out_rng;
    logic              rd_en;
    logic [1:0]        flt_d, flt_q;
    logic              valid_q;
    logic [31:0]       rd_data;
    logic              rd_par_err;
    logic [1:0]        fault;

    // Ready comes straight from the state register, so a request coinciding
    // with ld_start in RUN is still accepted.
    assign bus.fetch_ready = (state_q == ST_RUN);
    assign accept          = bus.fetch_req && bus.fetch_ready;
    assign word_idx        = bus.fetch_addr[ADDR_W-1:2];
    assign misal           = bus.fetch_addr[1:0] != 2'b00;
    assign out_rng         = (word_idx >> AW) != '0;
    assign rd_en           = accept && !misal && !out_rng;

    // Address fault decode; misalignment outranks range.
    always_comb begin
        flt_d = FLT_OK;
        if (misal) begin
            flt_d = FLT_MISAL;
        end else if (out_rng) begin
            flt_d = FLT_RANGE;
        end
    end

    // Load FSM next state, pointer and write strobe; a start pulse always restarts.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.ld_start) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    if (bus.ld_valid) begin
                        wr_en = 1'b1;
                        ptr_d = ptr_q + 1'b1;
                        if (ptr_q == AW'(DEPTH - 1)) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (bus.ld_end) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Load FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Fetch response registers; the fault code holds until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            flt_q   <= FLT_OK;
        end else begin
            valid_q <= accept;
            if (accept) begin
                flt_q <= flt_d;
            end
        end
    end

    imem_sdp_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (ptr_q),
        .wr_data    (bus.ld_data),
        .rd_en      (rd_en),
        .rd_addr    (word_idx[AW-1:0]),
        .rd_data    (rd_data),
        .rd_par_err (rd_par_err)
    );

    // Parity is only consulted when the address itself was clean.
    assign fault = (flt_q != FLT_OK) ? flt_q : (rd_par_err ? FLT_PAR : FLT_OK);

    assign bus.fetch_valid = valid_q;
    assign bus.fetch_fault = fault;
    assign bus.fetch_data  = (fault != FLT_OK) ? NOP_INSN : rd_data;
    assign bus.ld_ptr      = ptr_q;
    assign bus.ld_overflow = ovf_q;

endmodule

// File: tb/tb_imem_sdp_loader.sv
// tb/tb_imem_sdp_loader.sv - self-checking bench for imem_sdp_loader (parity case under IMEM_PARITY_EN)
module tb_imem_sdp_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          MD  = 256;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imem_sdp_loader_if #(.DEPTH(MD), .ADDR_W(32)) bus  ();
    imem_sdp_loader_if #(.DEPTH(4),  .ADDR_W(32)) bus4 ();

    imem_sdp_loader #(.DEPTH(MD), .ADDR_W(32), .INIT_FILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imem_sdp_loader #(.DEPTH(4), .ADDR_W(32), .INIT_FILE("")) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the DEPTH=256 instance
    logic [31:0] m_mem [MD];
    bit          m_par_bad [MD];
    bit          m_load  = 1'b0;
    int          m_ptr   = 0;
    bit          m_ovf   = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = NOP;
    int          m_fault = 0;
    logic [31:0] m_a;

    initial begin
        for (int i = 0; i < MD; i++) begin
            m_mem[i]     = NOP;
            m_par_bad[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_load = 1'b0; m_ptr = 0; m_ovf = 1'b0;
            m_valid = 1'b0; m_data = NOP; m_fault = 0;
        end else begin
            m_valid = bus.fetch_req && !m_load;
            if (m_valid) begin
                m_a = bus.fetch_addr;
                if (m_a % 4 != 0) begin
                    m_fault = 1; m_data = NOP;
                end else if (m_a / 4 >= MD) begin
                    m_fault = 2; m_data = NOP;
                end else if (m_par_bad[m_a / 4]) begin
                    m_fault = 3; m_data = NOP;
                end else begin
                    m_fault = 0; m_data = m_mem[m_a / 4];
                end
            end
            if (!m_load) begin
                if (bus.ld_start) begin m_load = 1'b1; m_ptr = 0; m_ovf = 1'b0; end
            end else if (bus.ld_start) begin
                m_ptr = 0; m_ovf = 1'b0;
            end else begin
                if (bus.ld_valid) begin
                    m_mem[m_ptr] = bus.ld_data;
                    m_ptr = (m_ptr + 1) % MD;
                    if (m_ptr == 0) m_ovf = 1'b1;
                end
                if (bus.ld_end) m_load = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_ready", 32'(bus.fetch_ready), 32'(!m_load));
        chk("m_valid", 32'(bus.fetch_valid), 32'(m_valid));
        chk("m_data",  bus.fetch_data, m_data);
        chk("m_fault", 32'(bus.fetch_fault), 32'(m_fault));
        chk("m_ptr",   32'(bus.ld_ptr), 32'(m_ptr));
        chk("m_ovf",   32'(bus.ld_overflow), 32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f, input string name);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        tick();
        bus.fetch_req  = 1'b0;
        chk({name, "_valid"}, 32'(bus.fetch_valid), 32'd1);
        chk({name, "_data"},  bus.fetch_data, d);
        chk({name, "_fault"}, 32'(bus.fetch_fault), 32'(f));
    endtask

    task automatic fetch_chk4(input logic [31:0] a, input logic [31:0] d, input logic [1:0] f, input string name);
        bus4.fetch_req  = 1'b1;
        bus4.fetch_addr = a;
        tick();
        bus4.fetch_req  = 1'b0;
        chk({name, "_valid"}, 32'(bus4.fetch_valid), 32'd1);
        chk({name, "_data"},  bus4.fetch_data, d);
        chk({name, "_fault"}, 32'(bus4.fetch_fault), 32'(f));
    endtask

    initial begin
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.ld_start = 0;
        bus.ld_valid = 0; bus.ld_data = 0; bus.ld_end = 0;
        bus4.fetch_req = 0; bus4.fetch_addr = 0; bus4.ld_start = 0;
        bus4.ld_valid = 0; bus4.ld_data = 0; bus4.ld_end = 0;
        reset = 1'b1;
        repeat (2) tick();

        chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
        chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
        chk("rst_data",  bus.fetch_data, NOP);
        chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
        chk("rst_ptr",   32'(bus.ld_ptr), 32'd0);
        chk("rst_ovf",   32'(bus.ld_overflow), 32'd0);
        reset = 1'b0;
        tick();

        // back-to-back fetches of the default image
        for (int i = 0; i < 3; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 32'(i * 4);
            tick();
            chk("b2b_valid", 32'(bus.fetch_valid), 32'd1);
            chk("b2b_data",  bus.fetch_data, NOP);
            chk("b2b_fault", 32'(bus.fetch_fault), 32'd0);
        end
        bus.fetch_req = 1'b0;
        tick();
        chk("b2b_drop", 32'(bus.fetch_valid), 32'd0);
        chk("b2b_hold", bus.fetch_data, NOP);

        // faults and range boundary
        fetch_chk(32'h6,   NOP, 2'b01, "misal");
        fetch_chk(32'h400, NOP, 2'b10, "range");
        fetch_chk(32'h402, NOP, 2'b01, "prio");
        fetch_chk(32'h3FC, NOP, 2'b00, "last");

        // load four words; fetches refused while loading
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("ld_ready", 32'(bus.fetch_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            bus.ld_valid  = 1'b1;
            bus.ld_data   = 32'hA + 32'(k);
            bus.fetch_req = 1'b1;
            bus.fetch_addr = 32'h0;
            tick();
            chk("ld_ready_k", 32'(bus.fetch_ready), 32'd0);
            chk("ld_noresp",  32'(bus.fetch_valid), 32'd0);
        end
        bus.ld_valid = 1'b0; bus.fetch_req = 1'b0; bus.ld_end = 1'b1;
        tick();
        bus.ld_end = 1'b0;
        chk("ld_done_ready", 32'(bus.fetch_ready), 32'd1);
        chk("ld_done_ptr",   32'(bus.ld_ptr), 32'd4);

        // ld_valid outside LOAD has no effect
        bus.ld_valid = 1'b1; bus.ld_data = 32'h33;
        tick();
        bus.ld_valid = 1'b0;
        chk("run_wr_ptr", 32'(bus.ld_ptr), 32'd4);
        fetch_chk(32'h0,  32'hA, 2'b00, "rd0");
        fetch_chk(32'h4,  32'hB, 2'b00, "rd1");
        fetch_chk(32'h8,  32'hC, 2'b00, "rd2");
        fetch_chk(32'hC,  32'hD, 2'b00, "rd3");
        fetch_chk(32'h10, NOP,   2'b00, "rd4");

        // request coinciding with ld_start is still served
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4; bus.ld_start = 1'b1;
        tick();
        bus.fetch_req = 1'b0; bus.ld_start = 1'b0;
        chk("pend_valid", 32'(bus.fetch_valid), 32'd1);
        chk("pend_data",  bus.fetch_data, 32'hB);
        chk("pend_ready", 32'(bus.fetch_ready), 32'd0);

        // write together with end: the write lands, then RUN
        bus.ld_valid = 1'b1; bus.ld_data = 32'h11; bus.ld_end = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.ld_end = 1'b0;
        chk("wrend_ready", 32'(bus.fetch_ready), 32'd1);
        chk("wrend_ptr",   32'(bus.ld_ptr), 32'd1);
        fetch_chk(32'h0, 32'h11, 2'b00, "wrend_rd");

        // start wins over valid and end
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 32'h22; bus.ld_end = 1'b1;
        tick();
        bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_end = 1'b0;
        chk("sw_ready", 32'(bus.fetch_ready), 32'd0);
        chk("sw_ptr",   32'(bus.ld_ptr), 32'd0);
        bus.ld_end = 1'b1;
        tick();
        bus.ld_end = 1'b0;
        chk("sw_exit", 32'(bus.fetch_ready), 32'd1);
        fetch_chk(32'h0, 32'h11, 2'b00, "sw_rd");

        // reset in the middle of a load keeps written words
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h55;
        tick();
        bus.ld_data = 32'h66;
        tick();
        bus.ld_valid = 1'b0;
        chk("mr_ptr_pre", 32'(bus.ld_ptr), 32'd2);
        reset = 1'b1;
        #2;
        chk("mr_ready", 32'(bus.fetch_ready), 32'd1);
        chk("mr_ptr",   32'(bus.ld_ptr), 32'd0);
        tick();
        reset = 1'b0;
        fetch_chk(32'h0, 32'h55, 2'b00, "mr_rd0");
        fetch_chk(32'h4, 32'h66, 2'b00, "mr_rd1");
        fetch_chk(32'h8, 32'hC,  2'b00, "mr_rd2");

        // DEPTH=4 pointer wrap and sticky overflow
        bus4.ld_start = 1'b1;
        tick();
        bus4.ld_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus4.ld_valid = 1'b1;
            bus4.ld_data  = 32'h100 + 32'(k);
            tick();
            if (k == 3) begin
                chk("d4_ovf3", 32'(bus4.ld_overflow), 32'd0);
                chk("d4_ptr3", 32'(bus4.ld_ptr), 32'd3);
            end
            if (k == 4) begin
                chk("d4_ovf4", 32'(bus4.ld_overflow), 32'd1);
                chk("d4_ptr4", 32'(bus4.ld_ptr), 32'd0);
            end
        end
        bus4.ld_valid = 1'b0;
        chk("d4_ovf", 32'(bus4.ld_overflow), 32'd1);
        chk("d4_ptr", 32'(bus4.ld_ptr), 32'd1);
        bus4.ld_end = 1'b1;
        tick();
        bus4.ld_end = 1'b0;
        fetch_chk4(32'h0,  32'h105, 2'b00, "d4_rd0");
        fetch_chk4(32'h4,  32'h102, 2'b00, "d4_rd1");
        fetch_chk4(32'hC,  32'h104, 2'b00, "d4_rd3");
        fetch_chk4(32'h10, NOP,     2'b10, "d4_range");

`ifdef IMEM_PARITY_EN
        // corrupt one stored bit of word 3 (holds 0xD)
        force dut.u_ram.mem[3] = 32'h0000_000C;
        m_par_bad[3] = 1'b1;
        fetch_chk(32'hC, NOP, 2'b11, "parity");
        fetch_chk(32'h8, 32'hC, 2'b00, "parity_clean");
        release dut.u_ram.mem[3];
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
